// File: rtl/mesh_fifo_pkg.sv
// Shared types and helpers for the mesh terminal FIFO bank.
`define MESH_PCKG_T(W) logic [(W)-1:0]

package mesh_fifo_pkg;

    localparam logic [7:0] BCAST_ID_DEF = 8'hFF;
    localparam int MAX_PCKG = 512;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Callers zero-extend the packet to MAX_PCKG bits and pass its real width.
    function automatic logic [7:0] tgt_byte(
        input logic [MAX_PCKG-1:0] p,
        input int sz
    );
        return p[sz-1 -: 8];
    endfunction

endpackage

// File: rtl/mesh_term_fifo_bank_if.sv
// Write/read bundle between the stimulus side and the FIFO bank.
interface mesh_term_fifo_bank_if
    import mesh_fifo_pkg::*;
#(
    parameter int PCKG_SZ    = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CH     = 16,
    parameter int CNT_W      = cnt_w(FIFO_DEPTH)
);
    logic [NUM_CH-1:0]         push;
    logic [NUM_CH*PCKG_SZ-1:0] data_in;
    logic                      bcast_push;
    logic [PCKG_SZ-1:0]        bcast_data;
    logic [NUM_CH-1:0]         pop;
    logic [NUM_CH*PCKG_SZ-1:0] data_out;
    logic [NUM_CH-1:0]         pndng;
    logic [NUM_CH-1:0]         full;
    logic [NUM_CH*CNT_W-1:0]   count;
    logic [NUM_CH-1:0]         ovf;
    logic [NUM_CH-1:0]         ovf_clr;
    logic                      bcast_err;

    modport master (
        output push, data_in, bcast_push, bcast_data, pop, ovf_clr,
        input  data_out, pndng, full, count, ovf, bcast_err
    );

    modport slave (
        input  push, data_in, bcast_push, bcast_data, pop, ovf_clr,
        output data_out, pndng, full, count, ovf, bcast_err
    );
endinterface

// File: rtl/term_fifo.sv
// Single first-word-fall-through terminal channel.
module term_fifo
    import mesh_fifo_pkg::*;
#(
    parameter int PCKG_SZ    = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_req,
    input  logic [PCKG_SZ-1:0] wr_data,
    input  logic               pop,
    output logic [PCKG_SZ-1:0] data_out,
    output logic               pndng,
    output logic               full,
    output logic [CNT_W-1:0]   count,
    output logic               ovf_set
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef `MESH_PCKG_T(PCKG_SZ) pckg_t;

    pckg_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             do_pop;
    logic             do_wr;

    assign pndng    = (cnt_q != '0);
    assign full     = (cnt_q == DEPTH_C);
    assign count    = cnt_q;
    assign do_pop   = pop && pndng;
    // A pop frees a slot in the same edge, so a full channel still accepts.
    assign do_wr    = wr_req && (!full || do_pop);
    assign ovf_set  = wr_req && full && !pop;
    assign data_out = pndng ? mem[rd_ptr] : '0;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= nxt(wr_ptr);
            if (do_pop)
                rd_ptr <= nxt(rd_ptr);
            unique case ({do_wr, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/mesh_term_fifo_bank.sv
// Bank of terminal FIFOs with broadcast write, occupancy and
// sticky overflow flags.
module mesh_term_fifo_bank
    import mesh_fifo_pkg::*;
#(
    parameter int         PCKG_SZ    = 40,
    parameter int         FIFO_DEPTH = 4,
    parameter int         NUM_CH     = 16,
    parameter logic [7:0] BCAST_ID   = BCAST_ID_DEF,
    parameter int         CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input logic                  clk,
    input logic                  reset,
    mesh_term_fifo_bank_if.slave bus
);
    localparam int PAD = MAX_PCKG - PCKG_SZ;

    logic [NUM_CH-1:0] wr_req;
    logic [NUM_CH-1:0] col;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] ovf_q;
    logic              bcast_bad;
    logic              bcast_err_q;

    assign bcast_bad = bus.bcast_push &&
        (tgt_byte({{PAD{1'b0}}, bus.bcast_data}, PCKG_SZ) != BCAST_ID);

    // Broadcast wins; a per-channel push in the same cycle is a collision.
    assign wr_req = bus.bcast_push ? '1 : bus.push;
    assign col    = bus.bcast_push ? bus.push : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [PCKG_SZ-1:0] wr_data;

        assign wr_data = bus.bcast_push ? bus.bcast_data
                                        : bus.data_in[i*PCKG_SZ +: PCKG_SZ];

        term_fifo #(
            .PCKG_SZ    (PCKG_SZ),
            .FIFO_DEPTH (FIFO_DEPTH),
            .CNT_W      (CNT_W)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .wr_req   (wr_req[i]),
            .wr_data  (wr_data),
            .pop      (bus.pop[i]),
            .data_out (bus.data_out[i*PCKG_SZ +: PCKG_SZ]),
            .pndng    (bus.pndng[i]),
            .full     (bus.full[i]),
            .count    (bus.count[i*CNT_W +: CNT_W]),
            .ovf_set  (ovf_set[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q       <= '0;
            bcast_err_q <= 1'b0;
        end else begin
            ovf_q       <= (ovf_q & ~bus.ovf_clr) | ovf_set | col;
            bcast_err_q <= bcast_bad;
        end
    end

    assign bus.ovf       = ovf_q;
    assign bus.bcast_err = bcast_err_q;
endmodule
